// File: rtl/axi4_fp_write_gate_pkg.sv
// Shared definitions for the AXI4 front-port write gate: bus width defaults,
// burst encodings and the gate's state encoding.
package axi4_fp_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DRAIN} state_t;

  // AXI encodes burst length as beats-1; nine bits hold the full 256-beat case.
  function automatic logic [8:0] beats_of(input logic [7:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/axi4_fp_write_gate_if.sv
// AW + W channel bundle. The master drives valid and payload; the slave drives ready.
interface axi4_fp_write_gate_if
  import axi4_fp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF
) ();

  logic              aw_valid;
  logic              aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;

  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready
  );

endinterface

// File: rtl/axi4_fp_write_gate_wfifo.sv
// Synchronous W-beat FIFO with full/empty flags. A full FIFO accepts a push
// in the same cycle as a pop.
module axi4_fp_wfifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the cleared pointers make every
  // stale entry unreachable, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi4_fp_write_gate.sv
// Holds each AW until its W beats are buffered (or the buffer fills), then
// forwards AW and drains W with a counter-generated WLAST.
module axi4_fp_write_gate
  import axi4_fp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int WDEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  axi4_fp_write_gate_if.slave   s,
  axi4_fp_write_gate_if.master  m,
  output logic                  err_wlast
);

  localparam int SW = DATA_W / 8;
  localparam int FW = DATA_W + SW;

  state_t            state;
  logic [8:0]        need;
  logic [8:0]        rcvd;
  logic [8:0]        sent;
  logic              aw_ready_q;
  logic              aw_valid_q;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [7:0]        aw_len_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic          w_fire;
  logic          w_last_exp;
  logic          m_w_fire;
  logic          m_w_last_d;

  assign s.aw_ready = aw_ready_q;
  assign s.w_ready  = (state != IDLE) && !fifo_full && (rcvd != need);
  assign w_fire     = s.w_valid && s.w_ready;
  assign w_last_exp = ((rcvd + 9'd1) == need);

  assign m.aw_valid = aw_valid_q;
  assign m.aw_id    = aw_id_q;
  assign m.aw_addr  = aw_addr_q;
  assign m.aw_len   = aw_len_q;
  assign m.aw_size  = aw_size_q;
  assign m.aw_burst = aw_burst_q;

  // W only leaves once AW has been accepted, so DRAIN gates the output valid.
  assign m_w_last_d             = (sent == (need - 9'd1));
  assign m.w_valid              = (state == DRAIN) && !fifo_empty;
  assign m.w_last               = m_w_last_d;
  assign {m.w_data, m.w_strb}   = fifo_rdata;
  assign m_w_fire               = m.w_valid && m.w_ready;

  axi4_fp_wfifo #(
    .WIDTH (FW),
    .DEPTH (WDEPTH)
  ) u_wfifo (
    .clock (clock),
    .reset (reset),
    .push  (w_fire),
    .wdata ({s.w_data, s.w_strb}),
    .pop   (m_w_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      aw_ready_q <= 1'b0;
      aw_valid_q <= 1'b0;
      need       <= '0;
      rcvd       <= '0;
      sent       <= '0;
      err_wlast  <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
    end else begin
      // Upstream WLAST is only audited; downstream WLAST comes from the counter.
      if (w_fire) begin
        rcvd <= rcvd + 9'd1;
        if (s.w_last != w_last_exp) err_wlast <= 1'b1;
      end
      if (m_w_fire) sent <= sent + 9'd1;

      case (state)
        IDLE: begin
          if (s.aw_valid && aw_ready_q) begin
            aw_id_q    <= s.aw_id;
            aw_addr_q  <= s.aw_addr;
            aw_len_q   <= s.aw_len;
            aw_size_q  <= s.aw_size;
            aw_burst_q <= s.aw_burst;
            need       <= beats_of(s.aw_len);
            rcvd       <= '0;
            sent       <= '0;
            aw_ready_q <= 1'b0;
            state      <= COLLECT;
          end else begin
            aw_ready_q <= 1'b1;
          end
        end
        COLLECT: begin
          // A full buffer releases AW early so long bursts stream through.
          if ((rcvd == need) || fifo_full) begin
            aw_valid_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (m.aw_ready) begin
            aw_valid_q <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_w_fire && m_w_last_d) begin
            aw_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_fp_write_gate.sv
// Scoreboard bench for axi4_fp_write_gate: stimulus queues expected AW/W,
// a negedge monitor pops and compares whenever the DUT hands data downstream.
module tb_axi4_fp_write_gate;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int WDEPTH = 16;

  logic clock;
  logic reset;
  logic err_wlast;

  axi4_fp_write_gate_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_if ();
  axi4_fp_write_gate_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

  axi4_fp_write_gate #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .WDEPTH (WDEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s         (s_if),
    .m         (m_if),
    .err_wlast (err_wlast)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [48:0] aw_q [$];
  logic [36:0] mw_q [$];

  int aw_delay = 0;
  int w_mode   = 0;
  int aw_wait  = 0;

  int sw_cnt        = 0;
  int mw_cnt        = 0;
  int aw_fire_cyc   = 0;
  int aw_rise_cyc   = 0;
  int aw_rise_beats = 0;
  bit aw_valid_seen = 0;
  bit aw_done       = 0;
  bit prev_stall    = 0;
  bit ready_pending = 0;
  logic [48:0] aw_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // Downstream ready generator: AW ready after aw_delay cycles, W ready per w_mode.
  initial begin
    m_if.aw_ready = 1'b0;
    m_if.w_ready  = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (m_if.aw_valid) aw_wait++;
      else               aw_wait = 0;
      m_if.aw_ready = (aw_wait > aw_delay);
      case (w_mode)
        0:       m_if.w_ready = 1'b1;
        1:       m_if.w_ready = !m_if.w_ready;
        default: m_if.w_ready = 1'b0;
      endcase
    end
  end

  // Monitor: inputs are stable from posedge+1 to the next posedge, so a
  // handshake seen here fires at the coming edge.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall    = 0;
      aw_valid_seen = 0;
      aw_done       = 0;
      ready_pending = 0;
    end else begin
      if (ready_pending) begin
        check("s_aw_ready_after_last", s_if.aw_ready, 1);
        ready_pending = 0;
      end
      if (m_if.aw_valid && !aw_valid_seen) begin
        aw_rise_cyc   = cyc;
        aw_rise_beats = sw_cnt;
      end
      aw_valid_seen = m_if.aw_valid;
      if (s_if.w_valid && s_if.w_ready) sw_cnt++;

      if (m_if.w_valid) check("m_w_valid_after_aw", aw_done, 1);
      if (m_if.w_valid && m_if.w_ready) begin
        if (mw_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mw_unexpected_beat: got %0h, required no beat", m_if.w_data);
        end else begin
          check("mw_beat", {m_if.w_data, m_if.w_strb, m_if.w_last}, mw_q.pop_front());
        end
        mw_cnt++;
        if (m_if.w_last) begin
          ready_pending = 1;
          aw_done       = 0;
        end
      end

      if (m_if.aw_valid && prev_stall) check("m_aw_stable", {m_if.aw_id, m_if.aw_addr,
          m_if.aw_len, m_if.aw_size, m_if.aw_burst}, aw_hold);
      if (m_if.aw_valid && m_if.aw_ready) begin
        if (aw_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL maw_unexpected: got addr %0h, required no AW", m_if.aw_addr);
        end else begin
          check("m_aw_fields", {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size,
              m_if.aw_burst}, aw_q.pop_front());
        end
        aw_done = 1;
      end
      prev_stall = m_if.aw_valid && !m_if.aw_ready;
      aw_hold    = {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size, m_if.aw_burst};
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    s_if.aw_valid = 1'b1;
    s_if.aw_id    = id;
    s_if.aw_addr  = addr;
    s_if.aw_len   = len;
    s_if.aw_size  = 3'd2;
    s_if.aw_burst = burst;
    do begin
      @(negedge clock);
      n++;
    end while (!s_if.aw_ready && n < 200);
    check("aw_handshake", s_if.aw_ready, 1);
    if (s_if.aw_ready) begin
      @(posedge clock);
      #1;
      aw_fire_cyc = cyc;
      sw_cnt      = 0;
      mw_cnt      = 0;
    end
    s_if.aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    s_if.w_valid = 1'b1;
    s_if.w_data  = data;
    s_if.w_strb  = strb;
    s_if.w_last  = last;
    do begin
      @(negedge clock);
      n++;
    end while (!s_if.w_ready && n < 200);
    check("w_handshake", s_if.w_ready, 1);
    if (s_if.w_ready) begin
      @(posedge clock);
      #1;
    end
    s_if.w_valid = 1'b0;
  endtask

  // last_at: beat index carrying upstream WLAST; stall_at: beat held while the
  // buffer sits full behind a stalled downstream (-1 for none).
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] seed,
                           input logic [3:0] strb, input int last_at, input int stall_at);
    aw_q.push_back({id, addr, len, 3'd2, burst});
    for (int i = 0; i <= int'(len); i++)
      mw_q.push_back({seed + 32'(i), strb, (i == int'(len))});
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        s_if.w_valid = 1'b1;
        s_if.w_data  = seed + 32'(i);
        s_if.w_strb  = strb;
        s_if.w_last  = (i == last_at);
        for (int k = 0; k < 8; k++) begin
          @(negedge clock);
          check("stall_s_w_ready", s_if.w_ready, 0);
          check("stall_fifo_level", 64'(sw_cnt - mw_cnt), WDEPTH);
        end
        w_mode = 0;
        @(posedge clock);
        #1;
      end
      w_send(seed + 32'(i), strb, (i == last_at));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(mw_q.size() == 0 && s_if.aw_ready) && n < 500);
    check("burst_complete", (mw_q.size() == 0) && s_if.aw_ready, 1);
  endtask

  initial begin
    s_if.aw_valid = 1'b0;
    s_if.aw_id    = '0;
    s_if.aw_addr  = '0;
    s_if.aw_len   = '0;
    s_if.aw_size  = '0;
    s_if.aw_burst = '0;
    s_if.w_valid  = 1'b0;
    s_if.w_data   = '0;
    s_if.w_strb   = '0;
    s_if.w_last   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_s_aw_ready", s_if.aw_ready, 0);
    check("rst_s_w_ready",  s_if.w_ready,  0);
    check("rst_m_aw_valid", m_if.aw_valid, 0);
    check("rst_m_w_valid",  m_if.w_valid,  0);
    check("rst_err_wlast",  err_wlast,     0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_s_aw_ready", s_if.aw_ready, 1);

    // len=3, back-to-back beats, downstream always ready.
    run_burst(4'h1, 32'h0000_1000, 8'd3, 2'd1, 32'hA000_0000, 4'hF, 3, -1);
    wait_idle();
    check("len3_latency", 64'(aw_rise_cyc - aw_fire_cyc), 5);
    check("len3_err", err_wlast, 0);

    // len=0 single beat with sparse strobes.
    run_burst(4'h2, 32'h0000_2000, 8'd0, 2'd1, 32'hB000_0000, 4'hA, 0, -1);
    wait_idle();
    check("len0_latency", 64'(aw_rise_cyc - aw_fire_cyc), 2);
    check("len0_err", err_wlast, 0);

    // len=31 streams through a 16-deep buffer; slow AW ready, toggling W ready.
    aw_delay = 3;
    w_mode   = 1;
    run_burst(4'h3, 32'h0000_3000, 8'd31, 2'd1, 32'hC000_0000, 4'hF, 31, -1);
    wait_idle();
    check("len31_issue_at_full", aw_rise_beats, WDEPTH);
    check("len31_err", err_wlast, 0);
    aw_delay = 0;
    w_mode   = 0;

    // Early upstream WLAST on beat 2 of 3.
    run_burst(4'h4, 32'h0000_4000, 8'd2, 2'd0, 32'hD000_0000, 4'h3, 1, -1);
    wait_idle();
    check("early_last_err", err_wlast, 1);
    @(posedge clock);
    #1;
    check("err_sticky", err_wlast, 1);

    // Downstream W stalled with a full buffer: no overflow, intake blocked.
    w_mode = 2;
    run_burst(4'h5, 32'h0000_5000, 8'd19, 2'd1, 32'hE000_0000, 4'hF, 19, 16);
    wait_idle();

    // Reset in the middle of DRAIN after two of eight beats.
    run_burst(4'h6, 32'h0000_6000, 8'd7, 2'd1, 32'hF000_0000, 4'hF, 7, -1);
    begin
      int n = 0;
      do begin
        @(posedge clock);
        n++;
      end while (mw_cnt < 2 && n < 200);
      check("drain_progress", mw_cnt >= 2, 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_m_w_valid",  m_if.w_valid,  0);
    check("async_m_aw_valid", m_if.aw_valid, 0);
    check("async_s_aw_ready", s_if.aw_ready, 0);
    check("async_s_w_ready",  s_if.w_ready,  0);
    check("async_err_clear",  err_wlast,     0);
    mw_q.delete();
    aw_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    run_burst(4'h7, 32'h0000_7000, 8'd1, 2'd2, 32'h1234_5600, 4'hC, 1, -1);
    wait_idle();
    check("post_reset_err", err_wlast, 0);

    repeat (4) @(posedge clock);
    check("mw_queue_drained", mw_q.size(), 0);
    check("aw_queue_drained", aw_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
